// File: rtl/layer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// layer_sequencer_pkg
// Shared types and constants for the fully-connected layer sequencer:
//   VEC_LEN    - elements per activation / weight vector
//   RELU_DIV   - divider applied to non-negative neuron sums
//   LEAKY_DIV  - divider applied to negative neuron sums (leaky slope)
//   arr_t      - one vector of VEC_LEN 32-bit two's-complement integers
//   state_t    - sequencer FSM states
// ---------------------------------------------------------------------------
package layer_sequencer_pkg;

    localparam int VEC_LEN   = 4;
    localparam int RELU_DIV  = 2;
    localparam int LEAKY_DIV = 8;

    // Element i lives in bits [32*i +: 32]; each element is read as signed.
    typedef logic [VEC_LEN-1:0][31:0] arr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/neuron_operation.sv
// ---------------------------------------------------------------------------
// neuron_operation
// Combinational neuron: dot product of a weight row with the activation
// vector, followed by a leaky-ReLU implemented as signed division by
// RELU_DIV (sum >= 0) or LEAKY_DIV (sum < 0), truncating toward zero.
// Ports:
//   weights      in  arr_t  weight row
//   inputs       in  arr_t  activation vector
//   neuron_value out 32     activated result (signed)
// ---------------------------------------------------------------------------
module neuron_operation
    import layer_sequencer_pkg::*;
(
    input  arr_t               weights,
    input  arr_t               inputs,
    output logic signed [31:0] neuron_value
);

    logic signed [31:0] sum;

    // SystemVerilog signed '/' already truncates toward zero.
    function automatic logic signed [31:0] activate(input logic signed [31:0] x);
        if (x >= 0) begin
            return x / RELU_DIV;
        end
        return x / LEAKY_DIV;
    endfunction

    // Accumulation wraps modulo 2^32, like plain integer arithmetic.
    always_comb begin
        sum = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            sum = sum + $signed(weights[i]) * $signed(inputs[i]);
        end
    end

    assign neuron_value = activate(sum);

endmodule

// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
// Runs one fully-connected layer through a single shared neuron_operation.
// On an accepted start the activation vector and layer size are latched;
// each neuron row is then fetched from weight memory, evaluated, and
// written to the result buffer (FETCH -> LOAD -> CALC -> WRITE per row).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                layer request (honoured only in IDLE)
//   layer_size [ADDR_W:0] neuron count, saturated to MAX_NEURONS
//   y_in                 previous-layer activations
//   abort                abandon current layer, back to IDLE next cycle
//   busy                 layer in progress (FETCH..WRITE)
//   done                 one-cycle completion pulse
//   w_rd_en, w_addr      weight-row read request (data one cycle later)
//   w_data               weight row from memory
//   res_we, res_addr,
//   res_data             result write, held until res_ready
//   res_ready            result buffer accepts the write
// All outputs are registers or pure state decodes.
// ---------------------------------------------------------------------------
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int MAX_NEURONS = 16,
    parameter int ADDR_W      = $clog2(MAX_NEURONS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W:0]    layer_size,
    input  arr_t               y_in,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               w_rd_en,
    output logic [ADDR_W-1:0]  w_addr,
    input  arr_t               w_data,
    output logic               res_we,
    output logic [ADDR_W-1:0]  res_addr,
    output logic signed [31:0] res_data,
    input  logic               res_ready
);

    localparam logic [ADDR_W:0] MAX_SIZE = (ADDR_W+1)'(MAX_NEURONS);

    function automatic logic [ADDR_W:0] sat_size(input logic [ADDR_W:0] n);
        return (n > MAX_SIZE) ? MAX_SIZE : n;
    endfunction

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W:0]    size_reg;
    arr_t               w_reg;
    arr_t               y_reg;
    logic signed [31:0] res_reg;
    logic signed [31:0] neuron_value;
    logic               last_row;

    assign last_row = ({1'b0, idx} == (size_reg - 1'b1));

    neuron_operation neuron_unit (
        .weights      (w_reg),
        .inputs       (y_reg),
        .neuron_value (neuron_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    // An empty layer completes without touching memory.
                    state_next = (layer_size == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_next = S_LOAD;
            S_LOAD:  state_next = S_CALC;
            S_CALC:  state_next = S_WRITE;
            S_WRITE: begin
                if (res_ready) begin
                    state_next = last_row ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // abort overrides everything, including a write being accepted.
        if (abort && (state != S_IDLE)) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            size_reg <= '0;
            w_reg    <= '0;
            y_reg    <= '0;
            res_reg  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && (layer_size != '0)) begin
                        y_reg    <= y_in;
                        size_reg <= sat_size(layer_size);
                        idx      <= '0;
                    end
                end
                S_LOAD:  w_reg   <= w_data;
                S_CALC:  res_reg <= neuron_value;
                S_WRITE: begin
                    if (res_ready && !abort && !last_row) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // idx is a register and only changes on accepted writes, so the
    // address/data seen by the result buffer stay frozen while stalled.
    assign busy     = (state == S_FETCH) || (state == S_LOAD) ||
                      (state == S_CALC)  || (state == S_WRITE);
    assign done     = (state == S_DONE);
    assign w_rd_en  = (state == S_FETCH);
    assign w_addr   = idx;
    assign res_we   = (state == S_WRITE);
    assign res_addr = idx;
    assign res_data = res_reg;

endmodule
